// File: rtl/prio_enc_arb.sv
// prio_enc_arb: latches request pulses and grants one encoded index at a time to a valid/ready consumer.
// Latency: one registered cycle from a req on an idle block to out_valid; back-to-back grants have no bubble.
// Backpressure: while out_ready is low the grant is held stable and new requests merge into pending.
// Optional feature: define PRIO_ENC_RR_EN for round-robin search starting below the last granted index.
module prio_enc_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         none_pending
);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   idx_nxt;
  logic [N-1:0]   pending_nxt;
  logic [N-1:0]   cand;
  logic [N-1:0]   sel_onehot;
  logic [W-1:0]   sel_idx;
  logic           load;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0]   last_idx, last_idx_nxt;
`endif

  assign cand         = pending | req;
  assign out_valid    = (state == S_HOLD);
  assign none_pending = ~(|pending) & ~out_valid;
  // The output register reloads when empty or when the consumer takes the current grant.
  assign load         = (state == S_EMPTY) || (out_valid && out_ready);

`ifdef PRIO_ENC_RR_EN
  // Round-robin pick: search downward from last_idx-1, wrapping, so last_idx is considered last.
  always_comb begin
    logic found;
    int   pos;
    found   = 1'b0;
    sel_idx = '0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(last_idx) + N - 1 - i) % N;
      if (!found && cand[pos]) begin
        found   = 1'b1;
        sel_idx = W'(pos);
      end
    end
  end
`else
  // Fixed-priority pick: the highest set index of cand wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel_idx = W'(i);
      end
    end
  end
`endif

  // Decode the selected index so the granted bit can be removed from pending.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == W'(i)) begin
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-register values for the EMPTY/HOLD grant register.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = out_idx;
    pending_nxt  = cand;
`ifdef PRIO_ENC_RR_EN
    last_idx_nxt = last_idx;
`endif
    if (load) begin
      if (|cand) begin
        state_nxt    = S_HOLD;
        idx_nxt      = sel_idx;
        // A req bit granted this cycle is consumed here, not re-latched.
        pending_nxt  = cand & ~sel_onehot;
`ifdef PRIO_ENC_RR_EN
        last_idx_nxt = sel_idx;
`endif
      end else begin
        // Nothing to grant: drop to EMPTY, keep the stale index for observability.
        state_nxt   = S_EMPTY;
        pending_nxt = '0;
      end
    end
  end

  // State and grant registers with synchronous reset; req in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_EMPTY;
      out_idx  <= '0;
      pending  <= '0;
`ifdef PRIO_ENC_RR_EN
      last_idx <= '0;
`endif
    end else begin
      state    <= state_nxt;
      out_idx  <= idx_nxt;
      pending  <= pending_nxt;
`ifdef PRIO_ENC_RR_EN
      last_idx <= last_idx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed-vector bench for prio_enc_arb (N=8); expectations are hand-computed per vector.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
// Round-robin expectations apply when PRIO_ENC_RR_EN is defined for the compile.
module tb_prio_enc_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         none_pending;

  int vec_cnt;
  int err_cnt;

  prio_enc_arb #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .pending      (pending),
    .none_pending (none_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid",   32'(out_valid),    32'd0);
    chk("rst_idx",     32'(out_idx),      32'd0);
    chk("rst_pending", 32'(pending),      32'd0);
    chk("rst_none",    32'(none_pending), 32'd1);

    // Single low-priority request, one-cycle latency, then idle.
    rst = 1'b0;
    req = 8'h00;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    req = 8'h01;
    step();
    chk("r1_valid", 32'(out_valid), 32'd1);
    chk("r1_idx",   32'(out_idx),   32'd0);
    req = 8'h00;
    step();
    chk("r1_drop",  32'(out_valid),    32'd0);
    chk("r1_none",  32'(none_pending), 32'd1);

    // Two simultaneous pulses drain highest first with no bubble.
    req = 8'hC0;
    step();
    chk("c0_idx7", 32'(out_idx), 32'd7);
    chk("c0_pend", 32'(pending), 32'h40);
    req = 8'h00;
    step();
    chk("c0_idx6",   32'(out_idx),   32'd6);
    chk("c0_valid6", 32'(out_valid), 32'd1);
    chk("c0_pend0",  32'(pending),   32'h00);
    step();
    chk("c0_drop", 32'(out_valid), 32'd0);

    // Backpressure holds the grant; later requests accumulate; re-req on held bit latches.
    out_ready = 1'b0;
    req = 8'h04;
    step();
    chk("bp_idx2", 32'(out_idx), 32'd2);
    req = 8'h08;
    step();
    chk("bp_hold_idx", 32'(out_idx), 32'd2);
    chk("bp_pend",     32'(pending), 32'h08);
    req = 8'h0C;
    step();
    chk("bp_merge", 32'(pending), 32'h0C);
    req = 8'h00;
    out_ready = 1'b1;
    step();
    chk("bp_idx3",  32'(out_idx), 32'd3);
    chk("bp_pend2", 32'(pending), 32'h04);
    step();
    chk("bp_idx2b", 32'(out_idx), 32'd2);
    step();
    chk("bp_drop", 32'(out_valid), 32'd0);

    // Held request pattern: fixed priority repeats 7, round-robin alternates 7/5.
    req = 8'hA0;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef PRIO_ENC_RR_EN
      chk($sformatf("a0_idx%0d", k), 32'(out_idx), (k % 2 == 0) ? 32'd7 : 32'd5);
`else
      chk($sformatf("a0_idx%0d", k), 32'(out_idx), 32'd7);
`endif
    end
    req = 8'h00;
    step();
    step();
    step();
    chk("a0_none", 32'(none_pending), 32'd1);

    // Reset while holding a grant with pending work; req during reset is ignored.
    out_ready = 1'b0;
    req = 8'h80;
    step();
    req = 8'h12;
    step();
    chk("pre_valid", 32'(out_valid), 32'd1);
    chk("pre_pend",  32'(pending),   32'h12);
    rst = 1'b1;
    req = 8'hFF;
    step();
    chk("mrst_valid", 32'(out_valid),    32'd0);
    chk("mrst_pend",  32'(pending),      32'd0);
    chk("mrst_none",  32'(none_pending), 32'd1);
    chk("mrst_idx",   32'(out_idx),      32'd0);
    rst = 1'b0;
    req = 8'h02;
    out_ready = 1'b1;
    step();
    chk("post_valid", 32'(out_valid), 32'd1);
    chk("post_idx",   32'(out_idx),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
